// File: rtl/systolic_pkg.sv
// systolic_pkg: shared array geometry and feeder state encoding
package systolic_pkg;
  localparam int WIDTH = 8;
  localparam int N = 4;
  typedef enum logic [2:0] {IDLE, W_FILL, W_SHIFT, STREAM, DRAIN} state_t;
endpackage

// File: rtl/skew_delay.sv
// skew_delay: DEPTH-cycle data+valid delay line used to skew rows and tag results
module skew_delay #(
  parameter int W = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);
  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst_n;
    assign o_data = i_data;
    assign o_valid = i_valid;
  end else begin : g_pipe
    logic [W-1:0]     r_d [DEPTH];
    logic [DEPTH-1:0] r_v;
    // shift data and valid one stage per cycle
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
        r_v <= '0;
      end else begin
        r_d[0] <= i_data;
        r_v[0] <= i_valid;
        for (int i = 1; i < DEPTH; i++) begin
          r_d[i] <= r_d[i-1];
          r_v[i] <= r_v[i-1];
        end
      end
    assign o_data = r_d[DEPTH-1];
    assign o_valid = r_v[DEPTH-1];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a weight tile, shifts it into the array, then streams skewed feature vectors
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = systolic_pkg::WIDTH,
  parameter int N = systolic_pkg::N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        num_vec,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [N*WIDTH-1:0] w_row,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [N*WIDTH-1:0] f_vec,
  output logic               ctrl,
  output logic [N*WIDTH-1:0] pe_in,
  output logic [N*WIDTH-1:0] feat_out,
  output logic [N-1:0]       in_en,
  output logic [N-1:0]       res_valid,
  output logic               busy,
  output logic               done
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(2 * N);
  state_t             r_state;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_cnt;
  logic [15:0]        r_left;
  logic [N*WIDTH-1:0] r_buf [N];
  logic [N*WIDTH-1:0] r_pe_in;
  logic [N*WIDTH-1:0] r_s0;
  logic               r_s0v;
  logic               r_ctrl;
  logic               r_busy;
  logic               r_done;
  logic               w_acc;
  logic [N-1:0]       w_unused_res;
  assign w_ready = r_state == W_FILL;
  assign f_ready = r_state == STREAM;
  assign w_acc = f_valid && f_ready;
  assign ctrl = r_ctrl;
  assign pe_in = r_pe_in;
  assign busy = r_busy;
  assign done = r_done;
  // job sequencing: fill buffer, shift weights last row first, stream, drain, report done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_row <= '0;
      r_cnt <= '0;
      r_left <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_pe_in <= '0;
      r_ctrl <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_ctrl <= 1'b0;
      r_pe_in <= '0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= W_FILL;
          r_busy <= 1'b1;
          r_row <= '0;
          r_cnt <= '0;
          r_left <= num_vec;
        end
        W_FILL: if (w_valid) begin
          r_buf[r_row] <= w_row;
          r_row <= r_row + 1'b1;
          if (r_row == RW'(N - 1)) begin
            r_state <= W_SHIFT;
            r_row <= '0;
          end
        end
        W_SHIFT: begin
          r_ctrl <= 1'b1;
          r_pe_in <= r_buf[RW'(N - 1) - r_row];
          r_row <= r_row + 1'b1;
          if (r_row == RW'(N - 1)) begin
            r_row <= '0;
            r_state <= (r_left != 16'd0) ? STREAM : DRAIN;
          end
        end
        STREAM: if (f_valid) begin
          r_left <= r_left - 16'd1;
          if (r_left == 16'd1) r_state <= DRAIN;
        end
        DRAIN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(2 * N - 1)) begin
            r_state <= IDLE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  // first skew stage: accepted vector or a zero bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s0 <= '0;
      r_s0v <= 1'b0;
    end else begin
      r_s0 <= w_acc ? f_vec : '0;
      r_s0v <= w_acc;
    end
  for (genvar r = 0; r < N; r++) begin : g_row
    skew_delay #(.W(WIDTH), .DEPTH(r)) u_row (
      .clk(clk),
      .rst_n(rst_n),
      .i_data(r_s0[r*WIDTH +: WIDTH]),
      .i_valid(r_s0v),
      .o_data(feat_out[r*WIDTH +: WIDTH]),
      .o_valid(in_en[r])
    );
  end
  for (genvar c = 0; c < N; c++) begin : g_res
    skew_delay #(.W(1), .DEPTH(N + c)) u_res (
      .clk(clk),
      .rst_n(rst_n),
      .i_data(1'b0),
      .i_valid(r_s0v),
      .o_data(w_unused_res[c]),
      .o_valid(res_valid[c])
    );
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized job stimulus with a timing/data scoreboard for the feeder outputs
module tb_systolic_feeder;
  import systolic_pkg::*;
  localparam int DW = N * WIDTH;
  typedef struct {
    int k;
    int i;
    int c;
    logic [DW-1:0] d;
  } ev_t;
  logic clk, rst_n, start, w_valid, w_ready, f_valid, f_ready, ctrl, busy, done;
  logic [15:0] num_vec;
  logic [DW-1:0] w_row, f_vec, pe_in, feat_out;
  logic [N-1:0] in_en, res_valid;
  ev_t exp_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  systolic_feeder #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .f_valid(f_valid), .f_ready(f_ready), .f_vec(f_vec),
    .ctrl(ctrl), .pe_in(pe_in), .feat_out(feat_out), .in_en(in_en),
    .res_valid(res_valid), .busy(busy), .done(done)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // edge index: at the negedge after rising edge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;
  function automatic string kn(int k);
    return k == 0 ? "feat" : k == 1 ? "res_valid" : k == 2 ? "ctrl" : "done";
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic expect_ev(int k, int i, int c, logic [DW-1:0] d);
    ev_t e;
    e.k = k; e.i = i; e.c = c; e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic observe(int k, int i, logic [DW-1:0] d);
    int f = -1;
    for (int j = 0; j < exp_q.size(); j++)
      if (f < 0 && exp_q[j].k == k && exp_q[j].i == i) f = j;
    checks++;
    if (f < 0) begin
      errors++;
      $display("FAIL unexpected %s[%0d] at cycle %0d data %0h", kn(k), i, cyc, d);
    end else begin
      if (exp_q[f].c != cyc || exp_q[f].d !== d) begin
        errors++;
        $display("FAIL %s[%0d]: got cycle %0d data %0h, expected cycle %0d data %0h",
                 kn(k), i, cyc, d, exp_q[f].c, exp_q[f].d);
      end
      exp_q.delete(f);
    end
  endtask
  // monitor: match every presented output event against the scoreboard
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      for (int r = 0; r < N; r++)
        if (in_en[r]) observe(0, r, DW'(feat_out[r*WIDTH +: WIDTH]));
        else chk("feat_bubble", 64'(feat_out[r*WIDTH +: WIDTH]), 64'd0);
      for (int c = 0; c < N; c++)
        if (res_valid[c]) observe(1, c, '0);
      if (ctrl) observe(2, 0, pe_in);
      else chk("pe_in_idle", 64'(pe_in), 64'd0);
      if (done) observe(3, 0, '0);
      for (int j = exp_q.size() - 1; j >= 0; j--)
        if (exp_q[j].c < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing %s[%0d]: expected at cycle %0d, now %0d", kn(exp_q[j].k), exp_q[j].i, exp_q[j].c, cyc);
          exp_q.delete(j);
        end
    end
  end
  task automatic chk_all_zero(string nm);
    chk({nm, "_ctl"}, 64'({ctrl, in_en, res_valid, busy, done, w_ready, f_ready}), 64'd0);
    chk({nm, "_pe_in"}, 64'(pe_in), 64'd0);
    chk({nm, "_feat"}, 64'(feat_out), 64'd0);
  endtask
  task automatic run_job(input int n, input int gapmode, input bit fixed_w, input bit ones,
                         input bit poke_start, input int rst_after);
    logic [DW-1:0] wbuf [N];
    logic [DW-1:0] row;
    int e, a, l, g;
    @(negedge clk);
    start = 1'b1;
    num_vec = 16'(n);
    @(negedge clk);
    start = 1'b0;
    num_vec = 16'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < N; i++) begin
      g = fixed_w ? 0 : int'($urandom_range(0, 2));
      repeat (g) begin
        w_valid = 1'b0;
        w_row = DW'($urandom);
        chk("w_ready_fill", 64'(w_ready), 64'd1);
        @(negedge clk);
      end
      if (fixed_w) for (int c = 0; c < N; c++) row[c*WIDTH +: WIDTH] = WIDTH'(i * N + c + 1);
      else row = DW'($urandom);
      wbuf[i] = row;
      w_valid = 1'b1;
      w_row = row;
      chk("w_ready_fill", 64'(w_ready), 64'd1);
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_row = '0;
    e = cyc;
    chk("w_ready_shift", 64'(w_ready), 64'd0);
    for (int i = 0; i < N; i++) expect_ev(2, 0, e + 1 + i, wbuf[N-1-i]);
    while (cyc < e + N) begin
      chk("f_ready_shift", 64'(f_ready), 64'd0);
      @(negedge clk);
    end
    l = e + N;
    for (int v = 0; v < n; v++) begin
      g = gapmode == 1 ? (v == 1 ? 2 : 0) : gapmode == 2 ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        f_valid = 1'b0;
        f_vec = DW'($urandom);
        chk("f_ready_stream", 64'(f_ready), 64'd1);
        @(negedge clk);
      end
      if (ones) for (int r = 0; r < N; r++) row[r*WIDTH +: WIDTH] = WIDTH'(1);
      else row = DW'($urandom);
      f_valid = 1'b1;
      f_vec = row;
      start = poke_start && v == 1;
      chk("f_ready_stream", 64'(f_ready), 64'd1);
      @(negedge clk);
      start = 1'b0;
      a = cyc;
      l = a;
      for (int r = 0; r < N; r++) expect_ev(0, r, a + r, DW'(row[r*WIDTH +: WIDTH]));
      for (int c = 0; c < N; c++) expect_ev(1, c, a + N + c, '0);
      if (v + 1 == rst_after) begin
        f_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk_all_zero("reset_mid_stream");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N + 4) begin
          chk("no_done_after_reset", 64'(done), 64'd0);
          @(negedge clk);
        end
        return;
      end
    end
    f_valid = 1'b0;
    expect_ev(3, 0, l + 2 * N, '0);
    while (cyc < l + 2 * N + 2) begin
      chk("f_ready_drain", 64'(f_ready), 64'd0);
      if (cyc == l + 2 * N - 1) chk("busy_before_done", 64'(busy), 64'd1);
      if (cyc == l + 2 * N) chk("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    num_vec = '0;
    w_valid = 1'b0;
    w_row = '0;
    f_valid = 1'b0;
    f_vec = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    run_job(1, 0, 1'b1, 1'b1, 1'b0, -1);
    run_job(3, 1, 1'b0, 1'b0, 1'b0, -1);
    run_job(0, 0, 1'b0, 1'b0, 1'b0, -1);
    run_job(4, 2, 1'b0, 1'b0, 1'b1, -1);
    run_job(5, 0, 1'b0, 1'b0, 1'b0, 2);
    run_job(2, 2, 1'b0, 1'b0, 1'b0, -1);
    repeat (6) run_job(int'($urandom_range(0, 6)), 2, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
